imul_dot_prod_seq: RTL and testbench

- Dot-product sequencer that wraps the variable-latency integer multiplier (64-bit `{a,b}` request, 32-bit product response, val/rdy on both sides).
- Accepts a stream of operand pairs terminated by a last flag and issues each pair to the multiplier in order.
- Consumes the multiplier responses and accumulates the products.
- Emits one 32-bit sum plus an element count per stream.

---
 rtl/imul_dot_prod_seq_if.sv | 55 +++++
 rtl/imul_dot_prod_seq.sv | 85 ++++++++
 tb/tb_imul_dot_prod_seq.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imul_dot_prod_seq_if.sv
// ============================================================================
// Module   : imul_dot_prod_seq_if
// Brief    : Handshake bundle of the dot-product sequencer (input stream,
//            multiplier request/response, result).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface imul_dot_prod_seq_if #(
   parameter int CNT_NBITS = 16
);
   logic                 in_val;
   logic                 in_rdy;
   logic [63:0]          in_msg;
   logic                 in_last;

   logic                 mul_req_val;
   logic                 mul_req_rdy;
   logic [63:0]          mul_req_msg;

   logic                 mul_resp_val;
   logic                 mul_resp_rdy;
   logic [31:0]          mul_resp_msg;

   logic                 out_val;
   logic                 out_rdy;
   logic [31:0]          out_msg;
   logic [CNT_NBITS-1:0] out_count;

   // Sequencer side
   modport slave (
      input  in_val, in_msg, in_last,
      output in_rdy,
      output mul_req_val, mul_req_msg,
      input  mul_req_rdy,
      input  mul_resp_val, mul_resp_msg,
      output mul_resp_rdy,
      output out_val, out_msg, out_count,
      input  out_rdy
   );

   // Environment side: operand source, multiplier and result sink
   modport master (
      output in_val, in_msg, in_last,
      input  in_rdy,
      input  mul_req_val, mul_req_msg,
      output mul_req_rdy,
      output mul_resp_val, mul_resp_msg,
      input  mul_resp_rdy,
      input  out_val, out_msg, out_count,
      output out_rdy
   );
endinterface

`default_nettype wire

// File: rtl/imul_dot_prod_seq.sv
// ============================================================================
// Module   : imul_dot_prod_seq
// Brief    : Streams operand pairs to an in-order multiplier and accumulates
//            the products into one sum + element count per stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imul_dot_prod_seq #(
   parameter int MAX_INFLIGHT = 2,
   parameter int CNT_NBITS    = 16
) (
   input  wire logic              clk,
   input  wire logic              reset,
   imul_dot_prod_seq_if.slave     bus
);

   localparam int c_IF_NBITS = $clog2(MAX_INFLIGHT + 1);
   localparam logic [c_IF_NBITS-1:0] c_MAX_INFLIGHT = c_IF_NBITS'(MAX_INFLIGHT);
   localparam logic [c_IF_NBITS-1:0] c_IF_ONE       = c_IF_NBITS'(1);
   localparam logic [CNT_NBITS-1:0]  c_CNT_ONE      = CNT_NBITS'(1);

   localparam logic [1:0] c_ST_ACCUM = 2'd0;
   localparam logic [1:0] c_ST_DRAIN = 2'd1;
   localparam logic [1:0] c_ST_DONE  = 2'd2;

   logic [1:0]            r_state;
   logic [31:0]           r_acc;
   logic [CNT_NBITS-1:0]  r_cnt;
   logic [c_IF_NBITS-1:0] r_inflight;

   logic w_issue_ok;
   logic w_in_go;
   logic w_resp_go;
   logic w_out_go;

   // Handshake outputs are gated by reset so nothing is offered while held.
   assign w_issue_ok = reset && (r_state == c_ST_ACCUM) && (r_inflight < c_MAX_INFLIGHT);

   assign bus.mul_req_val  = bus.in_val && w_issue_ok;
   assign bus.in_rdy       = bus.mul_req_rdy && w_issue_ok;
   assign bus.mul_req_msg  = bus.in_msg;
   assign bus.mul_resp_rdy = reset && (r_state != c_ST_DONE);
   assign bus.out_val      = reset && (r_state == c_ST_DONE);
   assign bus.out_msg      = r_acc;
   assign bus.out_count    = r_cnt;

   assign w_in_go   = bus.in_val && bus.in_rdy;
   assign w_resp_go = bus.mul_resp_val && bus.mul_resp_rdy;
   assign w_out_go  = bus.out_val && bus.out_rdy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= c_ST_ACCUM;
         r_acc      <= 32'd0;
         r_cnt      <= '0;
         r_inflight <= '0;
      end else begin
         case (r_state)
            c_ST_ACCUM: if (w_in_go && bus.in_last)            r_state <= c_ST_DRAIN;
            c_ST_DRAIN: if (w_resp_go && r_inflight == c_IF_ONE) r_state <= c_ST_DONE;
            c_ST_DONE:  if (w_out_go)                          r_state <= c_ST_ACCUM;
            default:                                           r_state <= c_ST_ACCUM;
         endcase

         // Responses never arrive in DONE, so clearing and accumulating are exclusive.
         if (w_out_go) begin
            r_acc <= 32'd0;
            r_cnt <= '0;
         end else if (w_resp_go) begin
            r_acc <= r_acc + bus.mul_resp_msg;
            r_cnt <= r_cnt + c_CNT_ONE;
         end

         if (w_in_go && !w_resp_go) begin
            r_inflight <= r_inflight + c_IF_ONE;
         end else if (!w_in_go && w_resp_go) begin
            r_inflight <= r_inflight - c_IF_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imul_dot_prod_seq.sv
// ============================================================================
// Module   : tb_imul_dot_prod_seq
// Brief    : Scoreboard bench for imul_dot_prod_seq with an in-order
//            variable-latency multiplier model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imul_dot_prod_seq;

   localparam int MAX_INFLIGHT = 2;
   localparam int CNT_NBITS    = 16;

   typedef struct {
      logic [31:0] prod;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0]          sum;
      logic [CNT_NBITS-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   imul_dot_prod_seq_if #(.CNT_NBITS(CNT_NBITS)) bus ();

   imul_dot_prod_seq #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_NBITS    (CNT_NBITS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   exp_t  exp_q[$];
   mreq_t mq[$];
   logic [31:0]          exp_sum = 32'd0;
   logic [CNT_NBITS-1:0] exp_cnt = '0;

   int cyc       = 0;
   int lat_fixed = 0;   // 0 selects random latency 1..5
   bit req_rand  = 1'b0;
   int req_low   = 0;
   int out_mode  = 1;   // 0 low, 1 high, 2 random

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: actual=timeout required=event", name);
   endtask

   // In-order multiplier: product queued on request, presented after its latency.
   initial begin
      mreq_t       r;
      logic [63:0] p;
      bus.mul_req_rdy  = 1'b1;
      bus.mul_resp_val = 1'b0;
      bus.mul_resp_msg = 32'd0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            mq.delete();
         end else begin
            if (bus.mul_resp_val && bus.mul_resp_rdy) void'(mq.pop_front());
            if (bus.mul_req_val && bus.mul_req_rdy) begin
               p      = {32'd0, bus.mul_req_msg[63:32]} * {32'd0, bus.mul_req_msg[31:0]};
               r.prod = p[31:0];
               r.due  = cyc + 1 + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5)));
               mq.push_back(r);
               chk("inflight_bound", 64'(mq.size() <= MAX_INFLIGHT), 64'd1);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (req_low > 0) begin
            req_low--;
            bus.mul_req_rdy = 1'b0;
         end else begin
            bus.mul_req_rdy = req_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         bus.mul_resp_val = (mq.size() > 0) && (mq[0].due <= cyc);
         bus.mul_resp_msg = bus.mul_resp_val ? mq[0].prod : $urandom;
      end
   end

   initial begin
      bus.out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (out_mode)
            0:       bus.out_rdy = 1'b0;
            1:       bus.out_rdy = 1'b1;
            default: bus.out_rdy = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   // Monitor: a presented result must match the oldest expected stream result.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && bus.out_val) begin
            if (exp_q.size() == 0) begin
               fail_bound("unexpected_out");
            end else begin
               chk("out_msg", 64'(bus.out_msg), 64'(exp_q[0].sum));
               chk("out_count", 64'(bus.out_count), 64'(exp_q[0].cnt));
               if (bus.out_rdy) void'(exp_q.pop_front());
            end
         end
         if (reset && !bus.mul_req_rdy) chk("in_rdy_blocked", 64'(bus.in_rdy), 64'd0);
      end
   end

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                            input bit last, input int gap);
      int          n;
      logic [63:0] p;
      bus.in_val = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #2;
      end
      bus.in_val  = 1'b1;
      bus.in_msg  = {a, b};
      bus.in_last = last;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.in_rdy) break;
         n++;
         if (n > 300) begin
            fail_bound("in_accept");
            bus.in_val = 1'b0;
            return;
         end
      end
      p = {32'd0, a} * {32'd0, b};
      exp_sum = exp_sum + p[31:0];
      exp_cnt = exp_cnt + 1'b1;
      if (last) begin
         exp_q.push_back('{sum: exp_sum, cnt: exp_cnt});
         exp_sum = 32'd0;
         exp_cnt = '0;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle_in();
      bus.in_val  = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic wait_drained();
      int n;
      idle_in();
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (exp_q.size() != 0) fail_bound("drain");
   endtask

   initial begin
      int n;
      int len;
      bus.in_val  = 1'b1;
      bus.in_msg  = 64'h0000_0003_0000_0005;
      bus.in_last = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_rdy", 64'(bus.in_rdy), 64'd0);
      chk("rst_mul_req_val", 64'(bus.mul_req_val), 64'd0);
      chk("rst_mul_resp_rdy", 64'(bus.mul_resp_rdy), 64'd0);
      chk("rst_out_val", 64'(bus.out_val), 64'd0);
      @(posedge clk);
      #2;
      idle_in();
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_in_rdy", 64'(bus.in_rdy), 64'd1);
      chk("post_rst_out_val", 64'(bus.out_val), 64'd0);
      @(posedge clk);
      #2;

      // Basic stream and 32-bit wrap
      send_pair(32'd2, 32'd3, 1'b0, 0);
      send_pair(32'd4, 32'd5, 1'b0, 0);
      send_pair(32'd6, 32'd7, 1'b1, 0);
      wait_drained();
      send_pair(32'hFFFF_FFFF, 32'd1, 1'b0, 1);
      send_pair(32'd2, 32'd1, 1'b1, 0);
      wait_drained();

      // Request and result backpressure
      req_low  = 5;
      out_mode = 0;
      send_pair(32'd1, 32'd1, 1'b0, 0);
      send_pair(32'd3, 32'd3, 1'b1, 0);
      idle_in();
      n = 0;
      while (!bus.out_val && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_val) fail_bound("done_reached");
      repeat (10) @(negedge clk);
      out_mode = 1;
      wait_drained();

      // Inflight limit with a fixed 4-cycle multiplier
      lat_fixed = 4;
      send_pair(32'd1, 32'd2, 1'b0, 0);
      send_pair(32'd3, 32'd4, 1'b0, 0);
      bus.in_val  = 1'b1;
      bus.in_msg  = {32'd5, 32'd6};
      bus.in_last = 1'b1;
      @(negedge clk);
      chk("inflight_block_in_rdy", 64'(bus.in_rdy), 64'd0);
      @(posedge clk);
      #2;
      send_pair(32'd5, 32'd6, 1'b1, 0);
      wait_drained();
      lat_fixed = 0;

      // Reset in the middle of a stream discards the partial sum
      send_pair(32'd7, 32'd7, 1'b0, 0);
      idle_in();
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #2;
      reset   = 1'b1;
      exp_sum = 32'd0;
      exp_cnt = '0;
      send_pair(32'd1, 32'd9, 1'b1, 0);
      wait_drained();

      // Back-to-back single-element streams
      send_pair(32'd5, 32'd5, 1'b1, 0);
      send_pair(32'd2, 32'd2, 1'b1, 0);
      wait_drained();

      // Randomized streams under random backpressure and latency
      req_rand = 1'b1;
      out_mode = 2;
      for (int s = 0; s < 20; s++) begin
         len = int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++) begin
            send_pair($urandom, $urandom, (i == len - 1), int'($urandom_range(0, 2)));
         end
      end
      wait_drained();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
